spe_clocked_accumulator: RTL and testbench
==========================================

# spe_clocked_accumulator

Clocked, parametrised spike processing element for the SNN mesh. It accepts partial-sum packets on a valid/ready port and accumulates them into per-neuron membrane potentials. Once all expected partial sums for a neuron have arrived, it fires threshold spikes with reset-by-subtraction. Spike packets leave through an internal output FIFO. It replaces the unclocked depacketize/compute/packetize SPE chain at router endpoints that run on the synchronous fabric.

## Interface
Parameters:
- PE_ID, 0: 4-bit address of this PE. Incoming ADDR field must match it.
- OUT_ADDR, 0: 4-bit destination address placed on spike packets.
- NUM_NEURONS, 8: neurons held, 1..32.
- NUM_PSUM_SRC, 3: partial sums per neuron per timestep before evaluation.
- PSUM_W, 13: signed partial-sum width, carried in data[PSUM_W-1:0].
- MEM_W, 16: signed membrane width.
- THRESHOLD, 64: positive firing threshold.
- NUM_TIMESTEPS, 10: timestep counter modulus.
- OUT_FIFO_DEPTH, 4: spike FIFO entries, ≥2.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: synchronous active-low reset.
- in_valid / in_ready, input / output, 1: input handshake.
- in_pkt, input, 33: packet. ADDR is [32:29], OPCODE is [28:25], DATA is [24:0].
- out_valid / out_ready, output / input, 1: output handshake.
- out_pkt, output, 33: spike packet.
- err_pulse, output, 1: one-cycle pulse when a packet is dropped.
- timestep, output, 8: current timestep.

## Operation
- Transfer occurs on a cycle where valid and ready are both 1.
- in_pkt is accepted only when in_valid & in_ready.
- Input opcodes:
  - PSUM (4'h3): DATA[24:20] is the neuron index; DATA[PSUM_W-1:0] is the sign-extended partial sum.
  - TS_END (4'h7): ends the current timestep.
  - MEM_CLR (4'hF): zeroes all membranes and counters.
- Drop rule: a packet is dropped, with err_pulse asserted in stage 2, if any of these holds. No state changes.
  - ADDR ≠ PE_ID.
  - Unknown opcode.
  - PSUM with neuron index ≥ NUM_NEURONS.
  - PSUM for a neuron whose count already equals NUM_PSUM_SRC.
- PSUM handling:
  - mem[idx] ← sat(mem[idx] + psum). Saturate at ±(2^(MEM_W-1)-1 / -2^(MEM_W-1)).
  - cnt[idx]++.
  - When cnt reaches NUM_PSUM_SRC and the new mem ≥ THRESHOLD: push a spike packet and set mem ← mem − THRESHOLD.
  - When cnt reaches NUM_PSUM_SRC and mem < THRESHOLD: keep the residual; no spike.
  - Only one spike is fired per neuron per timestep, even if mem ≥ 2·THRESHOLD.
- Spike packet fields: ADDR = OUT_ADDR, OPCODE = 4'h5, DATA[24:20] = idx, DATA[7:0] = timestep, all other bits 0.
- TS_END handling: clear all cnt; timestep ← (timestep+1) mod NUM_TIMESTEPS. Membranes are retained.
- MEM_CLR handling: mem and cnt are all zeroed; timestep is unchanged.
- Ordering: all operations are strictly in acceptance order. A TS_END or MEM_CLR affects only packets accepted after it.

## Timing
- Two-stage pipeline:
  - S1: decode, register the packet, read mem/cnt.
  - S2: add, compare, write back, FIFO push.
- Forwarding: back-to-back PSUMs to the same neuron forward the S2 result into S1. Per-neuron arithmetic must equal serial processing.
- Forwarding also covers a TS_END or MEM_CLR in S2 with a PSUM in S1: the PSUM sees cleared cnt/mem.
- Throughput: one packet per cycle.
- Latency: spike packet appears on out_pkt/out_valid 2 cycles after the accepting edge when the FIFO is empty.
- in_ready = rst_n_q & (FIFO free entries, minus in-flight S1/S2 potential pushes, ≥ 1). The FIFO therefore never overflows and no spike is ever lost.
- in_ready depends only on registers, never on in_valid.
- out_valid stays high with out_pkt stable until out_ready.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Reset values:
  - out_valid 0, out_pkt 0, err_pulse 0, timestep 0, in_ready 0.
  - All mem, cnt and pipeline valids 0; FIFO empty.
- Reset mid-operation discards in-flight packets and FIFO contents.
- in_ready rises the first cycle after rst_n returns high.

## Structure
- spe_pkg: OPC_PSUM/OPC_TS_END/OPC_MEM_CLR/OPC_SPIKE, field positions (ADDR_START=32…DATA_END=0), PKT_W=33, a packet struct typedef.
- Sub-module spe_out_fifo: parametrised sync FIFO (WIDTH, DEPTH) exposing a free-count output.
- mem/cnt are flop arrays; no SRAM.

## Test plan
- Fire, defaults: PSUM idx 2 with values 30, 20, 25 → single spike: ADDR 0, OPC 5, DATA[24:20]=2, DATA[7:0]=0. Afterwards mem[2]=11.
- Below threshold and carry-over: PSUM idx 5 with values 10, 10, 10 → no spike, mem=30. TS_END → timestep=1. Then 20, 10, 5 → spike with timestep 1, mem[5]=1.
- Back-to-back hazard: idx 1 with 40, 40, −10 on consecutive cycles → spike, mem[1]=6. Result matches serial processing.
- Drops: ADDR=PE_ID+1, opcode 4'h9, idx 8, and a 4th PSUM to a completed neuron → err_pulse ×4, no state change, no spike.
- Backpressure: out_ready=0, fire 6 neurons in a row → in_ready drops once FIFO+pipeline reach depth. Release out_ready → all 6 spikes arrive in order, none lost.
- Saturation, wrap and reset:
  - 3× PSUM of +4095 on a 16-bit membrane preloaded near max → clamps at 32767.
  - 10 TS_END → timestep wraps to 0.
  - rst_n low mid-stream → outputs go to reset values on the next edge.

Source files
------------

// File: rtl/spe_pkg.sv
// rtl/spe_pkg.sv - packet layout, opcodes and helpers shared by the spike PE
package spe_pkg;

  localparam int PKT_W = 33;

  // Packet field positions (msb/lsb of each field)
  localparam int ADDR_START = 32;
  localparam int ADDR_END   = 29;
  localparam int OPC_START  = 28;
  localparam int OPC_END    = 25;
  localparam int DATA_START = 24;
  localparam int DATA_END   = 0;
  localparam int IDX_START  = 24;
  localparam int IDX_END    = 20;
  localparam int TS_START   = 7;
  localparam int TS_STOP    = 0;

  localparam logic [3:0] OPC_PSUM    = 4'h3;
  localparam logic [3:0] OPC_SPIKE   = 4'h5;
  localparam logic [3:0] OPC_TS_END  = 4'h7;
  localparam logic [3:0] OPC_MEM_CLR = 4'hF;

  typedef struct packed {
    logic [3:0]  addr;
    logic [3:0]  opcode;
    logic [24:0] data;
  } spe_pkt_t;

  // Operation carried by stage 2 once stage 1 has decoded and validated a packet
  typedef enum logic [1:0] {
    OP_PSUM    = 2'd0,
    OP_TS_END  = 2'd1,
    OP_MEM_CLR = 2'd2,
    OP_DROP    = 2'd3
  } spe_op_e;

  function automatic spe_pkt_t make_spike(input logic [3:0] addr,
                                          input logic [4:0] idx,
                                          input logic [7:0] ts);
    spe_pkt_t p;
    p        = '0;
    p.addr   = addr;
    p.opcode = OPC_SPIKE;
    p.data[IDX_START:IDX_END] = idx;
    p.data[TS_START:TS_STOP]  = ts;
    return p;
  endfunction

endpackage

// File: rtl/spe_out_fifo.sv
// rtl/spe_out_fifo.sv - synchronous spike FIFO with free-entry count
module spe_out_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_tvalid,
  input  logic [WIDTH-1:0]             s_tdata,
  output logic                         m_tvalid,
  output logic [WIDTH-1:0]             m_tdata,
  input  logic                         m_tready,
  output logic [$clog2(DEPTH+1)-1:0]   free_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // Handshake decode; a push into a full FIFO is taken only when a pop frees the slot
  always_comb begin
    m_tvalid = (count_q != '0);
    m_tdata  = m_tvalid ? store_q[rd_ptr_q] : '0;
    do_pop   = m_tvalid && m_tready;
    do_push  = s_tvalid && ((count_q != CNT_FULL) || do_pop);
    free_cnt = CNT_FULL - count_q;
  end

  // Entry storage; never read while empty, so it needs no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      store_q[wr_ptr_q] <= s_tdata;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spe_clocked_accumulator.sv
// rtl/spe_clocked_accumulator.sv - two-stage clocked spike PE with membrane accumulation
module spe_clocked_accumulator
  import spe_pkg::*;
#(
  parameter logic [3:0] PE_ID          = 4'd0,
  parameter logic [3:0] OUT_ADDR       = 4'd0,
  parameter int         NUM_NEURONS    = 8,
  parameter int         NUM_PSUM_SRC   = 3,
  parameter int         PSUM_W         = 13,
  parameter int         MEM_W          = 16,
  parameter int         THRESHOLD      = 64,
  parameter int         NUM_TIMESTEPS  = 10,
  parameter int         OUT_FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_pkt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_pkt,
  output logic             err_pulse,
  output logic [7:0]       timestep
);

  localparam int IDX_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int CNT_W  = $clog2(NUM_PSUM_SRC + 1);
  localparam int FREE_W = $clog2(OUT_FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]        CNT_FULL = CNT_W'(NUM_PSUM_SRC);
  localparam logic signed [MEM_W-1:0] THR      = MEM_W'(THRESHOLD);
  localparam logic signed [MEM_W-1:0] MEM_MAX  = {1'b0, {(MEM_W-1){1'b1}}};
  localparam logic signed [MEM_W-1:0] MEM_MIN  = {1'b1, {(MEM_W-1){1'b0}}};
  localparam logic [7:0]              TS_LAST  = 8'(NUM_TIMESTEPS - 1);

  // Architectural state
  logic signed [MEM_W-1:0] mem_q [NUM_NEURONS];
  logic [CNT_W-1:0]        cnt_q [NUM_NEURONS];
  logic [7:0]              ts_q;
  logic                    rst_n_q;

  // Stage 1: raw accepted packet
  logic     s1_valid_q;
  spe_pkt_t s1_pkt_q;

  // Stage 2: decoded operation with operands already forwarded
  logic                    s2_valid_q;
  spe_op_e                 s2_op_q;
  logic [IDX_W-1:0]        s2_idx_q;
  logic signed [MEM_W-1:0] s2_psum_q;
  logic signed [MEM_W-1:0] s2_mem_q;
  logic [CNT_W-1:0]        s2_cnt_q;

  // Stage 2 results
  logic signed [MEM_W:0]   s2_sum;
  logic signed [MEM_W-1:0] s2_sat;
  logic signed [MEM_W-1:0] s2_mem_new;
  logic [CNT_W-1:0]        s2_cnt_new;
  logic                    s2_fire;
  spe_pkt_t                spike_pkt;

  // Stage 1 decode results (next state of stage 2)
  logic [4:0]              s1_idx_raw;
  logic [IDX_W-1:0]        s1_idx;
  logic signed [MEM_W-1:0] s1_psum_ext;
  logic signed [MEM_W-1:0] s1_mem_fwd;
  logic [CNT_W-1:0]        s1_cnt_fwd;
  spe_op_e                 s2_op_d;

  logic [FREE_W-1:0]       fifo_free;

  // Capture accepted packets; rst_n_q holds off in_ready until the cycle after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_n_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_pkt_q   <= '0;
    end else begin
      rst_n_q    <= 1'b1;
      s1_valid_q <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        s1_pkt_q <= in_pkt;
      end
    end
  end

  // Stage 2 arithmetic: saturating add, count update, threshold fire with subtraction
  always_comb begin
    s2_sum = {s2_mem_q[MEM_W-1], s2_mem_q} + {s2_psum_q[MEM_W-1], s2_psum_q};
    if (s2_sum[MEM_W] != s2_sum[MEM_W-1]) begin
      s2_sat = s2_sum[MEM_W] ? MEM_MIN : MEM_MAX;
    end else begin
      s2_sat = s2_sum[MEM_W-1:0];
    end
    s2_cnt_new = s2_cnt_q + CNT_W'(1);
    s2_fire    = s2_valid_q && (s2_op_q == OP_PSUM) &&
                 (s2_cnt_new == CNT_FULL) && (s2_sat >= THR);
    s2_mem_new = s2_fire ? (s2_sat - THR) : s2_sat;
    spike_pkt  = make_spike(OUT_ADDR, 5'(s2_idx_q), ts_q);
  end

  // Stage 1 decode: read neuron state, forward from stage 2, apply drop rules
  always_comb begin
    s1_idx_raw  = s1_pkt_q.data[IDX_START:IDX_END];
    s1_idx      = s1_idx_raw[IDX_W-1:0];
    s1_psum_ext = MEM_W'($signed(s1_pkt_q.data[PSUM_W-1:0]));
    s1_mem_fwd  = mem_q[s1_idx];
    s1_cnt_fwd  = cnt_q[s1_idx];
    if (s2_valid_q) begin
      case (s2_op_q)
        OP_PSUM: begin
          if (s2_idx_q == s1_idx) begin
            s1_mem_fwd = s2_mem_new;
            s1_cnt_fwd = s2_cnt_new;
          end
        end
        OP_TS_END: begin
          s1_cnt_fwd = '0;
        end
        OP_MEM_CLR: begin
          s1_mem_fwd = '0;
          s1_cnt_fwd = '0;
        end
        default: begin
        end
      endcase
    end

    s2_op_d = OP_DROP;
    if (s1_pkt_q.addr == PE_ID) begin
      case (s1_pkt_q.opcode)
        OPC_PSUM: begin
          if ((int'(s1_idx_raw) < NUM_NEURONS) && (s1_cnt_fwd != CNT_FULL)) begin
            s2_op_d = OP_PSUM;
          end
        end
        OPC_TS_END:  s2_op_d = OP_TS_END;
        OPC_MEM_CLR: s2_op_d = OP_MEM_CLR;
        default:     s2_op_d = OP_DROP;
      endcase
    end
  end

  // Stage 2 pipeline register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_op_q    <= OP_DROP;
      s2_idx_q   <= '0;
      s2_psum_q  <= '0;
      s2_mem_q   <= '0;
      s2_cnt_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_op_q    <= s2_op_d;
      s2_idx_q   <= s1_idx;
      s2_psum_q  <= s1_psum_ext;
      s2_mem_q   <= s1_mem_fwd;
      s2_cnt_q   <= s1_cnt_fwd;
    end
  end

  // Write back neuron state and timestep at the end of stage 2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        mem_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      ts_q <= '0;
    end else if (s2_valid_q) begin
      case (s2_op_q)
        OP_PSUM: begin
          mem_q[s2_idx_q] <= s2_mem_new;
          cnt_q[s2_idx_q] <= s2_cnt_new;
        end
        OP_TS_END: begin
          for (int i = 0; i < NUM_NEURONS; i++) begin
            cnt_q[i] <= '0;
          end
          ts_q <= (ts_q == TS_LAST) ? '0 : ts_q + 8'd1;
        end
        OP_MEM_CLR: begin
          for (int i = 0; i < NUM_NEURONS; i++) begin
            mem_q[i] <= '0;
            cnt_q[i] <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Accept only when a slot is reserved for every packet that might still push a spike
  always_comb begin
    in_ready  = rst_n_q &&
                (32'(fifo_free) >= (32'(s1_valid_q) + 32'(s2_valid_q) + 32'd1));
    err_pulse = s2_valid_q && (s2_op_q == OP_DROP);
    timestep  = ts_q;
  end

  spe_out_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (OUT_FIFO_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (s2_fire),
    .s_tdata  (spike_pkt),
    .m_tvalid (out_valid),
    .m_tdata  (out_pkt),
    .m_tready (out_ready),
    .free_cnt (fifo_free)
  );

endmodule

// File: tb/tb_spe_clocked_accumulator.sv
// tb/tb_spe_clocked_accumulator.sv - directed bench with behavioural PE model and spike scoreboard
`timescale 1ns/1ps
module tb_spe_clocked_accumulator;

  localparam logic [3:0] PE_ID    = 4'd0;
  localparam logic [3:0] OUT_ADDR = 4'd0;
  localparam int NN   = 8;
  localparam int NSRC = 3;
  localparam int THR  = 64;
  localparam int NTS  = 10;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, err_pulse;
  logic [32:0] in_pkt, out_pkt;
  logic [7:0]  timestep;

  always #5 clk = ~clk;

  spe_clocked_accumulator #(
    .PE_ID(PE_ID), .OUT_ADDR(OUT_ADDR), .NUM_NEURONS(NN), .NUM_PSUM_SRC(NSRC),
    .PSUM_W(13), .MEM_W(16), .THRESHOLD(THR), .NUM_TIMESTEPS(NTS), .OUT_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt),
    .err_pulse(err_pulse), .timestep(timestep)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int          m_mem [32];
  int          m_cnt [32];
  int          m_ts  = 0;
  int          m_err = 0;
  logic [32:0] exp_q [$];

  // Observed activity
  int          err_seen = 0;
  int          popped   = 0;
  logic [32:0] last_out = '0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_pkt   = '0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [32:0] psum_pkt(input logic [3:0] a, input logic [4:0] idx, input int v);
    logic [12:0] r;
    r = 13'(v);
    return {a, 4'h3, idx, 7'd0, r};
  endfunction

  function automatic logic [32:0] ctrl_pkt(input logic [3:0] a, input logic [3:0] opc);
    return {a, opc, 25'd0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 0;
      m_cnt[i] = 0;
    end
    m_ts = 0;
    exp_q.delete();
  endtask

  // Serial, in-order interpretation of one accepted packet
  task automatic model_accept(input logic [32:0] p);
    logic [3:0]  a, opc;
    logic [4:0]  idx;
    logic [12:0] raw;
    int          ps, v;
    a   = p[32:29];
    opc = p[28:25];
    idx = p[24:20];
    raw = p[12:0];
    ps  = int'($signed(raw));
    if (a != PE_ID) begin
      m_err++;
    end else if (opc == 4'h3) begin
      if (int'(idx) >= NN || m_cnt[idx] == NSRC) begin
        m_err++;
      end else begin
        v = m_mem[idx] + ps;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        m_cnt[idx]++;
        if (m_cnt[idx] == NSRC && v >= THR) begin
          exp_q.push_back({OUT_ADDR, 4'h5, idx, 12'd0, 8'(m_ts)});
          v = v - THR;
        end
        m_mem[idx] = v;
      end
    end else if (opc == 4'h7) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_ts = (m_ts + 1) % NTS;
    end else if (opc == 4'hF) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = 0;
        m_cnt[i] = 0;
      end
    end else begin
      m_err++;
    end
  endtask

  // Call between clock edges; returns 1 ns after the accepting edge
  task automatic send(input logic [32:0] p);
    int   w;
    logic rdy;
    w = 0;
    in_pkt   = p;
    in_valid = 1'b1;
    forever begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      w++;
      if (w > 2000) begin
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", w);
        break;
      end
    end
    if (rdy) model_accept(p);
    in_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every output handshake must match the model's next spike, in order
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (err_pulse === 1'b1) err_seen++;
      if (prev_stall) check("out_hold", out_pkt, prev_pkt);
      if (out_valid === 1'b1 && exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_spike: got 0x%0h expected no spike", out_pkt);
      end else if (out_valid === 1'b1 && out_ready === 1'b1) begin
        check("spike_pkt", out_pkt, exp_q.pop_front());
        last_out = out_pkt;
        popped++;
      end
      prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
      prev_pkt   = out_pkt;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, p0, w;
    model_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_pkt = '0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pkt", out_pkt, 0);
    check("rst_err", err_pulse, 0);
    check("rst_timestep", timestep, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_release_ready_low", in_ready, 0);
    settle(1);
    check("ready_after_reset", in_ready, 1);

    // Fire with defaults, including output latency
    send(psum_pkt(PE_ID, 5'd2, 30));
    send(psum_pkt(PE_ID, 5'd2, 20));
    send(psum_pkt(PE_ID, 5'd2, 25));
    @(negedge clk); check("lat_cycle0", out_valid, 0);
    @(negedge clk); check("lat_cycle1", out_valid, 0);
    @(negedge clk); check("lat_cycle2", out_valid, 1);
    check("fire_pkt_literal", out_pkt, 33'h0_0A20_0000);
    @(posedge clk); #1;
    settle(4);
    check("fire_mem2", dut.mem_q[2], 11);

    // Below threshold, then carry-over into the next timestep
    send(psum_pkt(PE_ID, 5'd5, 10));
    send(psum_pkt(PE_ID, 5'd5, 10));
    send(psum_pkt(PE_ID, 5'd5, 10));
    settle(4);
    check("below_mem5", dut.mem_q[5], 30);
    check("below_popped", popped, 1);
    send(ctrl_pkt(PE_ID, 4'h7));
    settle(4);
    check("ts_after_end", timestep, 1);
    send(psum_pkt(PE_ID, 5'd5, 20));
    send(psum_pkt(PE_ID, 5'd5, 10));
    send(psum_pkt(PE_ID, 5'd5, 5));
    settle(5);
    check("carry_pkt_literal", last_out, 33'h0_0A50_0001);
    check("carry_mem5", dut.mem_q[5], 1);

    // Back-to-back hazard on one neuron
    send(psum_pkt(PE_ID, 5'd1, 40));
    send(psum_pkt(PE_ID, 5'd1, 40));
    send(psum_pkt(PE_ID, 5'd1, -10));
    settle(5);
    check("hazard_mem1", dut.mem_q[1], 6);
    check("hazard_pkt_literal", last_out, 33'h0_0A10_0001);
    check("hazard_popped", popped, 3);

    // Drops: wrong address, unknown opcode, index out of range, completed neuron
    e0 = err_seen;
    p0 = popped;
    send(psum_pkt(PE_ID + 4'd1, 5'd0, 5));
    send(ctrl_pkt(PE_ID, 4'h9));
    send(psum_pkt(PE_ID, 5'd8, 5));
    send(psum_pkt(PE_ID, 5'd1, 5));
    settle(5);
    check("drop_err_count", err_seen - e0, 4);
    check("drop_err_model", err_seen, m_err);
    check("drop_mem1", dut.mem_q[1], 6);
    check("drop_mem0", dut.mem_q[0], 0);
    check("drop_no_spike", popped - p0, 0);

    // Backpressure: six spikes queued behind a stalled output
    send(ctrl_pkt(PE_ID, 4'hF));
    settle(3);
    out_ready = 1'b0;
    p0 = popped;
    fork
      begin
        for (int n = 0; n < 6; n++)
          for (int k = 0; k < 3; k++)
            send(psum_pkt(PE_ID, 5'(n), 30));
      end
      begin
        settle(80);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_none_popped", popped - p0, 0);
        out_ready = 1'b1;
      end
    join
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      settle(1);
      w++;
    end
    settle(2);
    check("bp_all_spikes", popped - p0, 6);
    check("bp_mem3", dut.mem_q[3], 26);

    // Saturation on neuron 7
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) send(psum_pkt(PE_ID, 5'd7, 4095));
      send(ctrl_pkt(PE_ID, 4'h7));
    end
    send(psum_pkt(PE_ID, 5'd7, 4095));
    send(psum_pkt(PE_ID, 5'd7, 4095));
    settle(4);
    check("sat_clamp", dut.mem_q[7], 32767);
    send(psum_pkt(PE_ID, 5'd7, 4095));
    settle(5);
    check("sat_after_fire", dut.mem_q[7], 32703);

    // Timestep wrap
    while (m_ts != 9) send(ctrl_pkt(PE_ID, 4'h7));
    settle(4);
    check("ts_nine", timestep, 9);
    send(ctrl_pkt(PE_ID, 4'h7));
    settle(4);
    check("ts_wrap", timestep, 0);
    check("err_model_final", err_seen, m_err);

    // Reset in the middle of traffic with a spike waiting in the FIFO
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(psum_pkt(PE_ID, 5'd3, 30));
    send(ctrl_pkt(PE_ID, 4'h7));
    settle(4);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_ts", timestep, 1);
    in_pkt = psum_pkt(PE_ID, 5'd4, 50);
    in_valid = 1'b1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_pkt", out_pkt, 0);
    check("mid_rst_err", err_pulse, 0);
    check("mid_rst_ts", timestep, 0);
    check("mid_rst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    settle(1);
    check("mid_rst_ready_back", in_ready, 1);
    settle(3);
    check("mid_rst_mem3", dut.mem_q[3], 0);
    check("mid_rst_mem4", dut.mem_q[4], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
